ring_rr_arbiter: RTL

- Round-robin arbiter that shares one resource among N requesters.
- Priority is held in a one-hot ring pointer that rotates past the last owner, so the pointer behaves like a ring counter.
- At most one requester is granted at a time.
- A hold limit prevents any requester from monopolising the resource.
- Sits between requesting agents and a shared datapath. Also exposes the pointer for debug and sequencing.

---
 rtl/ring_rr_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer and a per-grant hold limit.
// Grants are registered; a release always leaves one idle turnaround cycle.
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] owner,
    output logic [N-1:0]         ptr,
    output logic                 timeout
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state, state_d;
    logic [N-1:0]   grant_d, ptr_d;
    logic [IW-1:0]  owner_d;
    logic           timeout_d;
    logic [CW-1:0]  hold_cnt, hold_d;
    logic [IW-1:0]  ptr_idx, pick_idx;
    logic           pick_found;

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) ptr_idx = IW'(i);
        end
    end

    // Circular scan starting at the pointer position; first requester found wins.
    always_comb begin
        int j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_idx) + k;
            if (j >= N) j = j - N;
            if (!pick_found && req[IW'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        grant_d   = grant;
        owner_d   = owner;
        ptr_d     = ptr;
        hold_d    = hold_cnt;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    hold_d  = CW'(1);
                end
            end
            GRANT: begin
                if (!req[owner] || hold_cnt == CW'(MAX_HOLD)) begin
                    // Pointer moves one past the releasing owner; grant is its one-hot.
                    state_d   = IDLE;
                    grant_d   = '0;
                    owner_d   = '0;
                    ptr_d     = {grant[N-2:0], grant[N-1]};
                    hold_d    = '0;
                    timeout_d = req[owner];
                end else begin
                    hold_d = hold_cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            owner       <= '0;
            ptr         <= {{(N-1){1'b0}}, 1'b1};
            timeout     <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            grant_valid <= |grant_d;
            owner       <= owner_d;
            ptr         <= ptr_d;
            timeout     <= timeout_d;
            hold_cnt    <= hold_d;
        end
    end

endmodule
